// File: rtl/fp_alu_byte_sequencer.sv
// Purpose: byte-serial front end for the 32-bit FP ALU: cmd + A + B in, result + status out.
// Latency: alu_start the cycle after the last B byte; first result byte the cycle after alu_done.
// Backpressure: in_ready low outside IDLE/LOAD_A/LOAD_B; out_data held until out_ready.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   abort                  synchronous abort back to IDLE (ignored while IDLE)
//   in_valid/in_ready/in_data     inbound byte stream (cmd, A[7:0]..A[31:24], B[7:0]..B[31:24])
//   out_valid/out_ready/out_data  outbound byte stream (result[7:0]..result[31:24], status)
//   alu_start/alu_op/alu_a/alu_b  request to the ALU core
//   alu_done/alu_result/alu_flags response from the ALU core
//   busy                   high in every state except IDLE
module fp_alu_byte_sequencer #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NAN_RESULT     = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_SEND   = 3'd5;

  localparam logic [1:0] OP_RSVD = 2'b11;

  // Expiry is detected in the WAIT cycle whose increment takes the counter
  // to TIMEOUT_CYCLES-1, so the first result byte appears exactly
  // TIMEOUT_CYCLES cycles after the alu_start cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 2);

  localparam logic [7:0] ST_BAD_OP  = 8'h10;
  localparam logic [7:0] ST_TIMEOUT = 8'h20;

  logic [2:0]  state;
  logic [2:0]  byte_cnt;
  logic [7:0]  tmo_cnt;
  logic [31:0] res_q;
  logic [7:0]  status_q;
  logic        in_xfer;
  logic        out_xfer;

  // All handshake outputs decode registered state only, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready  = (state == S_IDLE) || (state == S_LOAD_A) || (state == S_LOAD_B);
  assign out_valid = (state == S_SEND);
  assign busy      = (state != S_IDLE);
  assign alu_start = (state == S_ISSUE) && (alu_op != OP_RSVD);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    out_data = 8'h00;
    if (state == S_SEND) begin
      case (byte_cnt)
        3'd0:    out_data = res_q[7:0];
        3'd1:    out_data = res_q[15:8];
        3'd2:    out_data = res_q[23:16];
        3'd3:    out_data = res_q[31:24];
        3'd4:    out_data = status_q;
        default: out_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_cnt <= 3'd0;
      tmo_cnt  <= 8'd0;
      res_q    <= 32'd0;
      status_q <= 8'd0;
      alu_op   <= 2'b00;
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
    end else if (abort && (state != S_IDLE)) begin
      // In IDLE abort is a no-op, so a command byte offered alongside it is
      // still taken rather than handshaken and dropped.
      state    <= S_IDLE;
      byte_cnt <= 3'd0;
      tmo_cnt  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_xfer) begin
            alu_op   <= in_data[1:0];
            byte_cnt <= 3'd0;
            state    <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (in_xfer) begin
            alu_a[{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
            if (byte_cnt == 3'd3) begin
              byte_cnt <= 3'd0;
              state    <= S_LOAD_B;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (in_xfer) begin
            alu_b[{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
            if (byte_cnt == 3'd3) begin
              byte_cnt <= 3'd0;
              state    <= S_ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        S_ISSUE: begin
          byte_cnt <= 3'd0;
          if (alu_op == OP_RSVD) begin
            res_q    <= NAN_RESULT;
            status_q <= ST_BAD_OP;
            state    <= S_SEND;
          end else begin
            tmo_cnt <= 8'd0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // done is checked first so a response on the expiry cycle wins.
          if (alu_done) begin
            res_q    <= alu_result;
            status_q <= {4'b0000, alu_flags};
            state    <= S_SEND;
          end else if (tmo_cnt == TMO_LAST) begin
            res_q    <= NAN_RESULT;
            status_q <= ST_TIMEOUT;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_xfer) begin
            if (byte_cnt == 3'd4) begin
              byte_cnt <= 3'd0;
              state    <= S_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          byte_cnt <= 3'd0;
          tmo_cnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_alu_byte_sequencer.sv
// Directed bench for fp_alu_byte_sequencer with a small programmable ALU responder.
module tb_fp_alu_byte_sequencer;

  localparam int          TMO = 64;
  localparam logic [31:0] NAN = 32'h7FC0_0000;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        busy;

  fp_alu_byte_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .NAN_RESULT    (NAN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .alu_start (alu_start),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .alu_flags (alu_flags),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int starts = 0;
  int start_cyc = 0;
  int first_ov_cyc = 0;
  int stab_err = 0;
  int rdy_viol = 0;

  int          cfg_lat = 3;
  logic [31:0] cfg_res = 32'd0;
  logic [3:0]  cfg_flg = 4'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ALU responder: alu_done pulses L cycles after the alu_start cycle; L<=0 never answers.
  initial begin
    int pend;
    pend       = 0;
    alu_done   = 1'b0;
    alu_result = 32'd0;
    alu_flags  = 4'd0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          alu_done   = 1'b1;
          alu_result = cfg_res;
          alu_flags  = cfg_flg;
        end
      end
      if (alu_start && cfg_lat > 0) pend = cfg_lat;
    end
  end

  // Protocol monitor, sampled after the testbench has driven its inputs for the cycle.
  initial begin
    logic prev_ov, prev_or, in_wait;
    logic [7:0] prev_od;
    prev_ov = 1'b0;
    prev_or = 1'b0;
    prev_od = 8'd0;
    in_wait = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (alu_start) begin
        starts++;
        start_cyc = cyc;
        in_wait   = 1'b1;
      end
      if (out_valid && !prev_ov) first_ov_cyc = cyc;
      if (out_valid || abort || !rst_n) in_wait = 1'b0;
      if (in_ready && (out_valid || alu_start || in_wait)) rdy_viol++;
      if (prev_ov && !prev_or && out_valid && (out_data != prev_od)) stab_err++;
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_od = out_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input int gap);
    send_byte(cmd, gap);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gap);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], gap);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_wait", out_valid, 1);
  endtask

  task automatic recv_frame(input int stall, output logic [39:0] got);
    got = '0;
    for (int i = 0; i < 5; i++) begin
      wait_out_valid();
      repeat (stall) @(negedge clk);
      got[8*i +: 8] = out_data;
      if (i == 4) chk("busy_before_last", busy, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("busy_after_frame", busy, 0);
    chk("out_valid_after_frame", out_valid, 0);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] res,
                          input logic [3:0] flg, input int gap, input int stall,
                          input logic [39:0] exp, input int exp_starts, input int exp_lat);
    int s0;
    logic [39:0] got;
    cfg_lat = lat;
    cfg_res = res;
    cfg_flg = flg;
    s0      = starts;
    send_frame(cmd, a, b, gap);
    recv_frame(stall, got);
    chk({tag, "_bytes"}, got, exp);
    chk({tag, "_starts"}, starts - s0, exp_starts);
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_b"}, alu_b, b);
    chk({tag, "_alu_op"}, alu_op, cmd[1:0]);
    if (exp_lat > 0) chk({tag, "_latency"}, first_ov_cyc - start_cyc, exp_lat);
  endtask

  initial begin
    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_op",    alu_op,    0);
    chk("rst_alu_a",     alu_a,     0);
    chk("rst_alu_b",     alu_b,     0);
    chk("rst_busy",      busy,      0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Add, ALU answers after 3 cycles: first byte 4 cycles after the start cycle.
    do_frame("add", 8'h00, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 4'h0,
             0, 0, 40'h00_40_40_00_00, 1, 4);
    // Mul with flags {nan=0, inf=1, zero=0, ovf=1}; cmd upper bits ignored.
    do_frame("mul", 8'hFE, 32'h7F00_0000, 32'h4000_0000, 2, 32'h7F80_0000, 4'b0101,
             0, 0, 40'h05_7F_80_00_00, 1, 3);
    // Reserved opcode: no start pulse, NaN result, bad_op status.
    do_frame("rsvd", 8'h03, 32'h1122_3344, 32'h5566_7788, 2, 32'h0BAD_0BAD, 4'hF,
             0, 0, 40'h10_7F_C0_00_00, 0, 0);
    // Timeout: ALU never answers.
    do_frame("tmo", 8'h01, 32'h3F80_0000, 32'h3F80_0000, -1, 32'h0, 4'h0,
             0, 0, 40'h20_7F_C0_00_00, 1, TMO);
    // done on the expiry cycle wins over the timeout.
    do_frame("tmo_edge", 8'h01, 32'hC000_0000, 32'h4000_0000, TMO - 1, 32'h1234_5678, 4'b1000,
             0, 0, 40'h08_12_34_56_78, 1, TMO);
    // Stalls: in_valid every other cycle, out_ready low 10 cycles per byte.
    do_frame("stall", 8'h00, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 4'h0,
             1, 10, 40'h00_40_40_00_00, 1, 4);

    // Abort after two A bytes, then a clean frame.
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_load_busy", busy, 0);
    do_frame("post_abort", 8'h00, 32'h3F80_0000, 32'h3F80_0000, 2, 32'h4000_0000, 4'h0,
             0, 0, 40'h00_40_00_00_00, 1, 3);

    // Abort while sending.
    cfg_lat = 2;
    send_frame(8'h01, 32'h4000_0000, 32'h3F80_0000, 0);
    wait_out_valid();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_send_out_valid", out_valid, 0);
    chk("abort_send_busy", busy, 0);

    // Async reset in the middle of SEND.
    cfg_lat = 2;
    send_frame(8'h02, 32'h4040_0000, 32'h4000_0000, 0);
    wait_out_valid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data",  out_data,  0);
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_busy",      busy,      0);
    chk("midrst_alu_a",     alu_a,     0);
    chk("midrst_alu_b",     alu_b,     0);
    chk("midrst_alu_op",    alu_op,    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("out_data_stable", stab_err, 0);
    chk("in_ready_low_when_busy", rdy_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
